// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
//
// Two-level branch direction predictor for the fetch stage. A pattern history
// table (PHT) of 2-bit saturating counters is indexed either by PC XOR global
// history (gshare, MODE=1) or by PC alone (bimodal, MODE=0). Each lookup
// produces a registered prediction and speculatively shifts the predicted
// direction into the global history register (GHR). Resolution from execute
// trains the counters and, on a mispredict, rebuilds the GHR from the snapshot
// carried down the pipe. After reset an init sweep writes every PHT entry to
// weakly-not-taken before lookups and updates are honoured.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_ni         synchronous active-low reset
//   pred_req_i     lookup request this cycle
//   pred_pc_i      PC of the branch being looked up
//   pred_valid_o   registered prediction valid
//   pred_taken_o   predicted direction (counter MSB)
//   pred_idx_o     PHT index used; returned later on upd_idx_i
//   pred_ghr_o     GHR before this lookup's speculative shift
//   upd_valid_i    branch resolved this cycle
//   upd_idx_i      PHT index of the resolved branch
//   upd_taken_i    actual direction
//   upd_mispred_i  resolved direction differed from prediction
//   upd_ghr_i      GHR snapshot of the resolved branch
//   ready_o        init sweep complete
//   miss_cnt_o     saturating mispredict count
// -----------------------------------------------------------------------------
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | sweeping the PHT to 2'b01, one entry per cycle; traffic ignored
// ST_RUN  | lookups, updates and repairs honoured
//
module gshare_predictor #(
    parameter int PC_BITS  = 32,
    parameter int IDX_BITS = 4,
    parameter int GHR_BITS = 4,
    parameter int MODE     = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                pred_req_i,
    input  logic [PC_BITS-1:0]  pred_pc_i,
    output logic                pred_valid_o,
    output logic                pred_taken_o,
    output logic [IDX_BITS-1:0] pred_idx_o,
    output logic [GHR_BITS-1:0] pred_ghr_o,

    input  logic                upd_valid_i,
    input  logic [IDX_BITS-1:0] upd_idx_i,
    input  logic                upd_taken_i,
    input  logic                upd_mispred_i,
    input  logic [GHR_BITS-1:0] upd_ghr_i,

    output logic                ready_o,
    output logic [15:0]         miss_cnt_o
);

    localparam int DEPTH = 1 << IDX_BITS;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_BITS-1:0] ptr_q, ptr_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [IDX_BITS-1:0] pred_idx_q, pred_idx_d;
    logic [GHR_BITS-1:0] pred_ghr_q, pred_ghr_d;
    logic [15:0]         miss_cnt_q, miss_cnt_d;

    // PHT storage: deliberately not reset, the init sweep fills it.
    logic [1:0]          pht_q [DEPTH];
    logic                pht_we;
    logic [IDX_BITS-1:0] pht_waddr;
    logic [1:0]          pht_wdata;

    logic [IDX_BITS-1:0] pc_idx;
    logic [IDX_BITS-1:0] ghr_ext;
    logic [IDX_BITS-1:0] lookup_idx;
    logic                lookup_taken;
    logic [GHR_BITS-1:0] ghr_shift;
    logic [GHR_BITS-1:0] ghr_repair;
    logic [1:0]          upd_cnt;
    logic [1:0]          upd_cnt_nxt;
    logic                unused_pc_bits;

    // ------------------------------------------------------------------
    // Index generation
    // ------------------------------------------------------------------
    // Branches are word aligned, so PC[1:0] carry no information.
    assign pc_idx = pred_pc_i[IDX_BITS+1:2];
    assign unused_pc_bits = ^{pred_pc_i[PC_BITS-1:IDX_BITS+2], pred_pc_i[1:0]};

    // GHR zero-extended into the low bits of the index.
    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_BITS-1:0] = ghr_q;
    end

    assign lookup_idx   = (MODE != 0) ? (pc_idx ^ ghr_ext) : pc_idx;
    assign lookup_taken = pht_q[lookup_idx][1];

    // ------------------------------------------------------------------
    // History shift helpers; written as loops so GHR_BITS=1 needs no
    // special-case slice.
    // ------------------------------------------------------------------
    always_comb begin
        ghr_shift = ghr_q;
        for (int i = GHR_BITS - 1; i > 0; i--) begin
            ghr_shift[i] = ghr_q[i-1];
        end
        ghr_shift[0] = lookup_taken;
    end

    always_comb begin
        ghr_repair = upd_ghr_i;
        for (int i = GHR_BITS - 1; i > 0; i--) begin
            ghr_repair[i] = upd_ghr_i[i-1];
        end
        ghr_repair[0] = upd_taken_i;
    end

    // ------------------------------------------------------------------
    // Saturating counter update
    // ------------------------------------------------------------------
    assign upd_cnt = pht_q[upd_idx_i];

    always_comb begin
        upd_cnt_nxt = upd_cnt;
        if (upd_taken_i) begin
            if (upd_cnt != 2'b11) begin
                upd_cnt_nxt = upd_cnt + 2'b01;
            end
        end else begin
            if (upd_cnt != 2'b00) begin
                upd_cnt_nxt = upd_cnt - 2'b01;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        ghr_d        = ghr_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_idx_d   = pred_idx_q;
        pred_ghr_d   = pred_ghr_q;
        miss_cnt_d   = miss_cnt_q;
        pht_we       = 1'b0;
        pht_waddr    = '0;
        pht_wdata    = 2'b01;

        unique case (state_q)
            ST_INIT: begin
                pht_we    = 1'b1;
                pht_waddr = ptr_q;
                pht_wdata = 2'b01;
                ptr_d     = ptr_q + IDX_BITS'(1);
                if (&ptr_q) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (pred_req_i) begin
                    pred_valid_d = 1'b1;
                    pred_taken_d = lookup_taken;
                    pred_idx_d   = lookup_idx;
                    pred_ghr_d   = ghr_q;
                    ghr_d        = ghr_shift;
                end

                if (upd_valid_i) begin
                    pht_we    = 1'b1;
                    pht_waddr = upd_idx_i;
                    pht_wdata = upd_cnt_nxt;

                    // Repair overrides any speculative shift this cycle.
                    if (upd_mispred_i) begin
                        ghr_d = ghr_repair;
                        if (miss_cnt_q != 16'hFFFF) begin
                            miss_cnt_d = miss_cnt_q + 16'd1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q        <= '0;
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
            pred_ghr_q   <= '0;
            miss_cnt_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_idx_q   <= pred_idx_d;
            pred_ghr_q   <= pred_ghr_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Writes are suppressed while reset is held so an aborted cycle leaves
    // the table untouched.
    always_ff @(posedge clk_i) begin
        if (pht_we && rst_ni) begin
            pht_q[pht_waddr] <= pht_wdata;
        end
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_taken_o = pred_taken_q;
    assign pred_idx_o   = pred_idx_q;
    assign pred_ghr_o   = pred_ghr_q;
    assign ready_o      = (state_q == ST_RUN);
    assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

    logic        clk;
    logic        rst_n;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [3:0]  upd_idx;
    logic        upd_taken;
    logic        upd_mispred;
    logic [3:0]  upd_ghr;

    logic        b_valid, b_taken, b_ready;
    logic [3:0]  b_idx, b_ghr;
    logic [15:0] b_miss;
    logic        g_valid, g_taken, g_ready;
    logic [3:0]  g_idx, g_ghr;
    logic [15:0] g_miss;

    int checks   = 0;
    int failures = 0;

    gshare_predictor #(.PC_BITS(32), .IDX_BITS(4), .GHR_BITS(4), .MODE(0)) u_bim (
        .clk_i(clk), .rst_ni(rst_n),
        .pred_req_i(pred_req), .pred_pc_i(pred_pc),
        .pred_valid_o(b_valid), .pred_taken_o(b_taken),
        .pred_idx_o(b_idx), .pred_ghr_o(b_ghr),
        .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken),
        .upd_mispred_i(upd_mispred), .upd_ghr_i(upd_ghr),
        .ready_o(b_ready), .miss_cnt_o(b_miss)
    );

    gshare_predictor #(.PC_BITS(32), .IDX_BITS(4), .GHR_BITS(4), .MODE(1)) u_gsh (
        .clk_i(clk), .rst_ni(rst_n),
        .pred_req_i(pred_req), .pred_pc_i(pred_pc),
        .pred_valid_o(g_valid), .pred_taken_o(g_taken),
        .pred_idx_o(g_idx), .pred_ghr_o(g_ghr),
        .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken),
        .upd_mispred_i(upd_mispred), .upd_ghr_i(upd_ghr),
        .ready_o(g_ready), .miss_cnt_o(g_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs, step past the edge, then drop the strobes.
    task automatic cyc(input logic req, input logic [31:0] pc, input logic uv,
                       input logic [3:0] uidx, input logic ut, input logic um,
                       input logic [3:0] ug);
        pred_req    = req;
        pred_pc     = pc;
        upd_valid   = uv;
        upd_idx     = uidx;
        upd_taken   = ut;
        upd_mispred = um;
        upd_ghr     = ug;
        @(posedge clk);
        #1;
        pred_req    = 1'b0;
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        cyc(1'b1, pc, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic update(input logic [3:0] idx, input logic taken);
        cyc(1'b0, 32'h0, 1'b1, idx, taken, 1'b0, 4'h0);
    endtask

    task automatic repair(input logic [3:0] idx, input logic taken, input logic [3:0] ghr);
        cyc(1'b0, 32'h0, 1'b1, idx, taken, 1'b1, ghr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        repeat (16) idle();
        checks++;
        if ({b_ready, g_ready} !== 2'b11) begin
            failures++;
            $display("FAIL do_reset_ready got=%b exp=11", {b_ready, g_ready});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        checks++;
        if ({b_valid, b_taken, b_idx, b_ghr, b_ready, b_miss} !== 27'h0) begin
            failures++;
            $display("FAIL reset_bim_outputs got=%h exp=0", {b_valid, b_taken, b_idx, b_ghr, b_ready, b_miss});
        end
        checks++;
        if ({g_valid, g_taken, g_idx, g_ghr, g_ready, g_miss} !== 27'h0) begin
            failures++;
            $display("FAIL reset_gsh_outputs got=%h exp=0", {g_valid, g_taken, g_idx, g_ghr, g_ready, g_miss});
        end
        rst_n = 1'b1;
        // Traffic during the sweep must be ignored.
        for (int e = 1; e <= 16; e++) begin
            cyc(1'b1, 32'h14, 1'b1, 4'h5, 1'b1, 1'b1, 4'hF);
            checks++;
            if ({b_ready, g_ready} !== ((e == 16) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL init_ready edge=%0d got=%b exp=%b", e, {b_ready, g_ready},
                         ((e == 16) ? 2'b11 : 2'b00));
            end
            checks++;
            if ({g_valid, g_miss, g_ghr} !== 21'h0) begin
                failures++;
                $display("FAIL init_ignored edge=%0d got=%h exp=0", e, {g_valid, g_miss, g_ghr});
            end
        end
        lookup(32'h14);
        checks++;
        if ({b_valid, b_taken, b_idx, b_ghr} !== {1'b1, 1'b0, 4'h5, 4'h0}) begin
            failures++;
            $display("FAIL reset_first_lookup_bim got=%h exp=%h", {b_valid, b_taken, b_idx, b_ghr}, {1'b1, 1'b0, 4'h5, 4'h0});
        end
        checks++;
        if ({g_valid, g_taken, g_idx, g_ghr} !== {1'b1, 1'b0, 4'h5, 4'h0}) begin
            failures++;
            $display("FAIL reset_first_lookup_gsh got=%h exp=%h", {g_valid, g_taken, g_idx, g_ghr}, {1'b1, 1'b0, 4'h5, 4'h0});
        end
        idle();
        checks++;
        if ({b_valid, g_valid} !== 2'b00) begin
            failures++;
            $display("FAIL idle_valid_low got=%b exp=00", {b_valid, g_valid});
        end
    endtask

    task automatic test_bimodal_train();
        do_reset();
        update(4'h5, 1'b1);
        update(4'h5, 1'b1);
        lookup(32'h14);
        checks++;
        if ({b_taken, b_idx, b_ghr} !== {1'b1, 4'h5, 4'b0000}) begin
            failures++;
            $display("FAIL bim_train_taken got=%h exp=%h", {b_taken, b_idx, b_ghr}, {1'b1, 4'h5, 4'b0000});
        end
        repeat (3) update(4'h5, 1'b1);
        update(4'h5, 1'b0);
        lookup(32'h14);
        checks++;
        if ({b_taken, b_idx, b_ghr} !== {1'b1, 4'h5, 4'b0001}) begin
            failures++;
            $display("FAIL bim_sat_high got=%h exp=%h", {b_taken, b_idx, b_ghr}, {1'b1, 4'h5, 4'b0001});
        end
        update(4'h5, 1'b0);
        lookup(32'h14);
        checks++;
        if ({b_taken, b_idx, b_ghr} !== {1'b0, 4'h5, 4'b0011}) begin
            failures++;
            $display("FAIL bim_decrement got=%h exp=%h", {b_taken, b_idx, b_ghr}, {1'b0, 4'h5, 4'b0011});
        end
        repeat (3) update(4'h5, 1'b0);
        update(4'h5, 1'b1);
        lookup(32'h14);
        checks++;
        if ({b_taken, b_idx, b_ghr} !== {1'b0, 4'h5, 4'b0110}) begin
            failures++;
            $display("FAIL bim_sat_low got=%h exp=%h", {b_taken, b_idx, b_ghr}, {1'b0, 4'h5, 4'b0110});
        end
        update(4'h5, 1'b1);
        lookup(32'h14);
        checks++;
        if ({b_taken, b_idx, b_ghr} !== {1'b1, 4'h5, 4'b1100}) begin
            failures++;
            $display("FAIL bim_retrain got=%h exp=%h", {b_taken, b_idx, b_ghr}, {1'b1, 4'h5, 4'b1100});
        end
    endtask

    task automatic test_gshare_sep();
        do_reset();
        repair(4'h0, 1'b1, 4'b0001);
        lookup(32'h20);
        checks++;
        if ({g_taken, g_idx, g_ghr} !== {1'b0, 4'hB, 4'b0011}) begin
            failures++;
            $display("FAIL gsh_index_xor got=%h exp=%h", {g_taken, g_idx, g_ghr}, {1'b0, 4'hB, 4'b0011});
        end
        update(4'hB, 1'b1);
        update(4'hB, 1'b1);
        repair(4'h0, 1'b0, 4'b0000);
        lookup(32'h20);
        checks++;
        if ({g_taken, g_idx, g_ghr} !== {1'b0, 4'h8, 4'b0000}) begin
            failures++;
            $display("FAIL gsh_separation got=%h exp=%h", {g_taken, g_idx, g_ghr}, {1'b0, 4'h8, 4'b0000});
        end
        repair(4'h0, 1'b1, 4'b0001);
        lookup(32'h20);
        checks++;
        if ({g_taken, g_idx, g_ghr, g_miss} !== {1'b1, 4'hB, 4'b0011, 16'd3}) begin
            failures++;
            $display("FAIL gsh_trained_path got=%h exp=%h", {g_taken, g_idx, g_ghr, g_miss}, {1'b1, 4'hB, 4'b0011, 16'd3});
        end
    endtask

    task automatic test_repair();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'h0;
        exp_seq[1] = 4'h1;
        exp_seq[2] = 4'h3;
        exp_seq[3] = 4'h7;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            update(exp_seq[i], 1'b1);
            update(exp_seq[i], 1'b1);
        end
        // Back-to-back lookups, one per cycle, walking the GHR to 1111.
        for (int i = 0; i < 4; i++) begin
            lookup(32'h0);
            checks++;
            if ({g_valid, g_taken, g_idx, g_ghr} !== {1'b1, 1'b1, exp_seq[i], exp_seq[i]}) begin
                failures++;
                $display("FAIL b2b_lookup n=%0d got=%h exp=%h", i, {g_valid, g_taken, g_idx, g_ghr},
                         {1'b1, 1'b1, exp_seq[i], exp_seq[i]});
            end
        end
        cyc(1'b1, 32'h0, 1'b1, 4'h2, 1'b0, 1'b1, 4'b0101);
        checks++;
        if ({g_taken, g_idx, g_ghr, g_miss} !== {1'b0, 4'hF, 4'hF, 16'd1}) begin
            failures++;
            $display("FAIL repair_cycle got=%h exp=%h", {g_taken, g_idx, g_ghr, g_miss}, {1'b0, 4'hF, 4'hF, 16'd1});
        end
        lookup(32'h0);
        checks++;
        if ({g_idx, g_ghr} !== {4'hA, 4'hA}) begin
            failures++;
            $display("FAIL repair_wins got=%h exp=%h", {g_idx, g_ghr}, {4'hA, 4'hA});
        end
        cyc(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0);
        checks++;
        if (g_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_req_valid got=%b exp=0", g_valid);
        end
        lookup(32'h0);
        checks++;
        if ({g_idx, g_ghr, g_miss} !== {4'h4, 4'h4, 16'd1}) begin
            failures++;
            $display("FAIL mispred_without_valid got=%h exp=%h", {g_idx, g_ghr, g_miss}, {4'h4, 4'h4, 16'd1});
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        cyc(1'b1, 32'hC, 1'b1, 4'h3, 1'b1, 1'b0, 4'h0);
        checks++;
        if ({b_taken, b_idx, g_taken, g_idx} !== {1'b0, 4'h3, 1'b0, 4'h3}) begin
            failures++;
            $display("FAIL hazard_pre_update got=%h exp=%h", {b_taken, b_idx, g_taken, g_idx}, {1'b0, 4'h3, 1'b0, 4'h3});
        end
        lookup(32'hC);
        checks++;
        if ({b_taken, g_taken, g_idx} !== {1'b1, 1'b1, 4'h3}) begin
            failures++;
            $display("FAIL hazard_post_update got=%h exp=%h", {b_taken, g_taken, g_idx}, {1'b1, 1'b1, 4'h3});
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            update(4'(i), 1'b1);
            update(4'(i), 1'b1);
        end
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        repeat (7) idle();
        checks++;
        if (b_ready !== 1'b0) begin
            failures++;
            $display("FAIL midsweep_ready got=%b exp=0", b_ready);
        end
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            idle();
            checks++;
            if (b_ready !== (e == 16)) begin
                failures++;
                $display("FAIL resweep_ready edge=%0d got=%b exp=%b", e, b_ready, (e == 16));
            end
        end
        for (int i = 0; i < 16; i++) begin
            lookup(32'(i * 4));
            checks++;
            if ({b_taken, b_idx} !== {1'b0, 4'(i)}) begin
                failures++;
                $display("FAIL resweep_entry idx=%0d got=%h exp=%h", i, {b_taken, b_idx}, {1'b0, 4'(i)});
            end
        end
        repeat (9) repair(4'h0, 1'b1, 4'b0111);
        checks++;
        if ({b_miss, g_miss} !== {16'd9, 16'd9}) begin
            failures++;
            $display("FAIL miss_count_9 got=%h exp=%h", {b_miss, g_miss}, {16'd9, 16'd9});
        end
        lookup(32'h0);
        checks++;
        if ({g_valid, g_idx, g_ghr} !== {1'b1, 4'hF, 4'hF}) begin
            failures++;
            $display("FAIL pre_reset_ghr got=%h exp=%h", {g_valid, g_idx, g_ghr}, {1'b1, 4'hF, 4'hF});
        end
        rst_n = 1'b0;
        idle();
        checks++;
        if ({g_valid, g_taken, g_idx, g_ghr, g_ready, g_miss} !== 27'h0) begin
            failures++;
            $display("FAIL run_reset_clear got=%h exp=0", {g_valid, g_taken, g_idx, g_ghr, g_ready, g_miss});
        end
        rst_n = 1'b1;
        repeat (16) idle();
        lookup(32'h0);
        checks++;
        if ({g_valid, g_idx, g_ghr, g_miss} !== {1'b1, 4'h0, 4'h0, 16'd0}) begin
            failures++;
            $display("FAIL run_reset_ghr got=%h exp=%h", {g_valid, g_idx, g_ghr, g_miss}, {1'b1, 4'h0, 4'h0, 16'd0});
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        pred_req    = 1'b0;
        pred_pc     = 32'h0;
        upd_valid   = 1'b0;
        upd_idx     = 4'h0;
        upd_taken   = 1'b0;
        upd_mispred = 1'b0;
        upd_ghr     = 4'h0;
        #1;
        test_reset();
        test_bimodal_train();
        test_gshare_sep();
        test_repair();
        test_same_cycle();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
